pll_rst_sequencer: RTL



---
 rtl/pll_rst_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pll_rst_sequencer.sv
// PLL bring-up and reset-tree sequencer: pulses the PLL steady reset, qualifies lock,
// then releases the downstream reset domains in order, recovering from lock loss.
module pll_rst_sequencer #(
  parameter int N_DOM         = 3,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int STAGE_GAP     = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pll_locked,
  input  logic             i_sw_rst,
  input  logic             i_clr_flag,
  output logic             o_pll_stdy_rst,
  output logic [N_DOM-1:0] o_rst_domain,
  output logic             o_ready,
  output logic             o_fail,
  output logic             o_lock_lost,
  output logic [1:0]       o_retry_cnt,
  output logic [2:0]       o_state
);

  localparam int REL_CYCLES = N_DOM * STAGE_GAP;
  localparam int MAX_AB     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD     = (STABLE_CYCLES > REL_CYCLES) ? STABLE_CYCLES : REL_CYCLES;
  localparam int CNT_MAX    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST     = CW'(REL_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [1:0]       retry_nx;
  logic [N_DOM-1:0] rst_dom_nx;
  logic             lock_loss;
  logic             lock_meta;
  logic             lock_s;

  // i_pll_locked comes from the PLL and is asynchronous to the reference clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= i_pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    retry_nx   = o_retry_cnt;
    rst_dom_nx = o_rst_domain;
    lock_loss  = 1'b0;
    if (i_sw_rst) begin
      state_nx = PLL_RST;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = STABLE;
            cnt_nx   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_nx = '0;
            if (o_retry_cnt == RETRY_MAX) begin
              state_nx = FAIL;
            end else begin
              state_nx = PLL_RST;
              retry_nx = o_retry_cnt + 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        // A lock drop while qualifying only restarts qualification, not the PLL
        STABLE: begin
          if (!lock_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nx = RELEASE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            lock_loss = 1'b1;
            state_nx  = PLL_RST;
            cnt_nx    = '0;
          end else begin
            for (int k = 0; k < N_DOM; k++) begin
              if (cnt == CW'((k + 1) * STAGE_GAP - 1)) rst_dom_nx[k] = 1'b0;
            end
            if (cnt == REL_LAST) begin
              state_nx = RUN;
              cnt_nx   = '0;
              retry_nx = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (!lock_s) begin
            lock_loss = 1'b1;
            state_nx  = PLL_RST;
            cnt_nx    = '0;
          end
        end
        FAIL: begin
          state_nx = FAIL;
        end
        default: begin
          state_nx = PLL_RST;
          cnt_nx   = '0;
        end
      endcase
    end
    // Domains can only be released while heading into RELEASE or RUN
    if (state_nx != RELEASE && state_nx != RUN) rst_dom_nx = '1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= PLL_RST;
      cnt            <= '0;
      o_pll_stdy_rst <= 1'b1;
      o_rst_domain   <= '1;
      o_ready        <= 1'b0;
      o_fail         <= 1'b0;
      o_lock_lost    <= 1'b0;
      o_retry_cnt    <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      o_pll_stdy_rst <= (state_nx == PLL_RST) || (state_nx == FAIL);
      o_rst_domain   <= rst_dom_nx;
      o_ready        <= (state_nx == RUN);
      o_fail         <= (state_nx == FAIL);
      o_retry_cnt    <= retry_nx;
      if (lock_loss) begin
        o_lock_lost <= 1'b1;
      end else if (i_clr_flag) begin
        o_lock_lost <= 1'b0;
      end
    end
  end

  assign o_state = state;

endmodule
